alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares a single instance of the team's `alu` between two requesters: requester 0 is the execute stage and requester 1 is an auxiliary unit (address/CSR helper).
- Valid/ready handshake per requester, round-robin grant, fixed 1-cycle latency.
- Each requester has its own one-entry registered response slot with backpressure.
- Sits between the requesters and the ALU. The ALU is instantiated inside this block; `i_alu_op` encoding is passed through unchanged.

Parameters:
- TAG_W, 4, width of the opaque request tag returned with each response.

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_reset  input  1  synchronous reset, active-high
- i_req0_valid  input  1  requester 0 has an operation
- o_req0_ready  output  1  requester 0 granted this cycle
- i_req0_op_a  input  32  operand A, requester 0
- i_req0_op_b  input  32  operand B, requester 0
- i_req0_alu_op  input  4  ALU opcode {funct7[5], funct3}, requester 0
- i_req0_tag  input  TAG_W  tag, requester 0
- o_rsp0_valid  output  1  response slot 0 full
- i_rsp0_ready  input  1  requester 0 consumes response
- o_rsp0_data  output  32  ALU result for requester 0
- o_rsp0_tag  output  TAG_W  tag echoed
- i_req1_* / o_req1_ready / o_rsp1_* / i_rsp1_ready  same as above, for requester 1
- o_grant_cnt0  output  32  grants to requester 0 (see Optional Feature)
- o_grant_cnt1  output  32  grants to requester 1
- o_conflict_cnt  output  32  cycles where both requesters were eligible

Behaviour:
- Reset (i_reset=1 at clock edge):
  - o_rspN_valid=0, o_rspN_data=0, o_rspN_tag=0.
  - Priority pointer = 0, meaning requester 0 wins the next tie.
  - Counters = 0.
  - o_reqN_ready=0 in any cycle where i_reset=1.
- Reset mid-operation: any result being captured that edge is discarded. Slots clear regardless of i_rspN_ready.
- Slot N is free when `!o_rspN_valid || i_rspN_ready`. Draining and refilling in the same cycle is allowed.
- Requester N is eligible when `i_reqN_valid && slotN free`.
- Grant rules (combinational):
  - At most one grant per cycle. o_reqN_ready = grantN.
  - Only one requester eligible: it is granted.
  - Both eligible: the requester named by the pointer is granted.
  - Neither eligible: no grant.
  - o_reqN_ready must not depend on o_reqN_ready of the other port (no combinational loop). It may depend on i_reqN_valid and i_rspN_ready.
- Pointer update: on a grant to N, pointer = 1-N at the next edge. With no grant, the pointer holds.
- Datapath:
  - The granted requester's op_a/op_b/alu_op drive the ALU in the same cycle.
  - The result and tag are registered into slot N at the edge. o_rspN_valid=1 from the next cycle.
  - Latency is exactly 1 cycle, from handshake edge to response valid.
  - With no grant, the ALU inputs are 0; the result is not captured.
- Slot behaviour:
  - A full slot holds data and tag stable until i_rspN_ready=1.
  - Drain with no refill: o_rspN_valid falls to 0 at the next edge.
  - Drain with a new grant the same cycle: the slot reloads and o_rspN_valid stays 1.
- A blocked requester (slot full, not draining) never stalls the other requester.
- Throughput: one operation per cycle total. Each requester is guaranteed one grant every 2 cycles while continuously eligible.
- Request inputs are sampled only on handshake; values are don't-care when valid=0.
- Unknown opcodes give result 0, matching ALU default behaviour; the response is still returned.

Optional Feature:
- Macro: ALU_ARBITER_STATS_EN.
- Defined:
  - o_grant_cntN increments by 1 at each edge where grantN=1.
  - o_conflict_cnt increments at each edge where both requesters are eligible.
  - All three counters are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on reset.
- Not defined: the three counter outputs are tied to 0 and no counter registers exist. Arbitration and datapath are identical in both builds.

Test Plan:
- Single requester: req0 ADD (op_a=5, op_b=7, tag=3), rsp0_ready=1 -> o_req0_ready=1 same cycle; next cycle o_rsp0_valid=1, data=12, tag=3.
- Contention: both valid every cycle, both rsp_ready=1, from reset -> grants 0,1,0,1...; req1 SUB (op_a=3, op_b=5) returns 0xFFFFFFFE; req0 SLT (op_a=0xFFFFFFFF, op_b=1) returns 1.
- Backpressure: rsp0_ready=0 after one result, req0 still valid, req1 valid -> o_req0_ready=0, req1 granted every cycle, slot 0 data held stable.
- Drain and refill: slot 0 full, rsp0_ready=1 and req0 valid the same cycle -> grant to 0, o_rsp0_valid stays 1, data updates to the new result.
- Reset mid-flight: assert i_reset on a grant cycle -> next cycle both o_rspN_valid=0, pointer=0; a tie after reset grants requester 0.
- Stats (ALU_ARBITER_STATS_EN defined): 10 contention cycles -> o_grant_cnt0=5, o_grant_cnt1=5, o_conflict_cnt=10. Undefined build: all counter outputs stay 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU. Requester 0 is the execute stage and requester 1 is
// the auxiliary unit. Grants are round-robin, and results arrive in a one-entry slot per requester.
// Latency: 1 cycle from the handshake edge to o_rspN_valid.
// Backpressure: a requester whose slot is full and not draining gets no grant. It never stalls the other requester.
// Ports: i_clk/i_reset (sync, active-high); per requester N: i_reqN_valid/o_reqN_ready,
//   i_reqN_op_a/op_b/alu_op/tag, o_rspN_valid/i_rspN_ready, o_rspN_data/tag;
//   o_grant_cnt0/1, o_conflict_cnt statistics.
// Optional: define ALU_ARBITER_STATS_EN to build the statistics counters; otherwise they read 0.

// Shared RV32I ALU. The opcode is {funct7[5], funct3}. Unknown opcodes yield 0.
module alu (
  input  logic [3:0]  alu_op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic [31:0] result_o
);
  logic [4:0] shamt;
  assign shamt = op_b_i[4:0];

  always_comb begin
    result_o = 32'd0;
    case (alu_op_i)
      4'b0000: result_o = op_a_i + op_b_i;                              // ADD
      4'b1000: result_o = op_a_i - op_b_i;                              // SUB
      4'b0001: result_o = op_a_i << shamt;                              // SLL
      4'b0010: result_o = {31'd0, $signed(op_a_i) < $signed(op_b_i)};   // SLT
      4'b0011: result_o = {31'd0, op_a_i < op_b_i};                     // SLTU
      4'b0100: result_o = op_a_i ^ op_b_i;                              // XOR
      4'b0101: result_o = op_a_i >> shamt;                              // SRL
      4'b1101: result_o = $unsigned($signed(op_a_i) >>> shamt);         // SRA
      4'b0110: result_o = op_a_i | op_b_i;                              // OR
      4'b0111: result_o = op_a_i & op_b_i;                              // AND
      default: result_o = 32'd0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  // requester 0 (execute stage)
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [31:0]      i_req0_op_a,
  input  logic [31:0]      i_req0_op_b,
  input  logic [3:0]       i_req0_alu_op,
  input  logic [TAG_W-1:0] i_req0_tag,
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [31:0]      o_rsp0_data,
  output logic [TAG_W-1:0] o_rsp0_tag,
  // requester 1 (auxiliary unit)
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [31:0]      i_req1_op_a,
  input  logic [31:0]      i_req1_op_b,
  input  logic [3:0]       i_req1_alu_op,
  input  logic [TAG_W-1:0] i_req1_tag,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [31:0]      o_rsp1_data,
  output logic [TAG_W-1:0] o_rsp1_tag,
  // statistics
  output logic [31:0]      o_grant_cnt0,
  output logic [31:0]      o_grant_cnt1,
  output logic [31:0]      o_conflict_cnt
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             ptr_q, ptr_d;            // requester that wins the next tie
  logic             rsp0_valid_q, rsp0_valid_d;
  logic [31:0]      rsp0_data_q, rsp0_data_d;
  logic [TAG_W-1:0] rsp0_tag_q, rsp0_tag_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [31:0]      rsp1_data_q, rsp1_data_d;
  logic [TAG_W-1:0] rsp1_tag_q, rsp1_tag_d;

  // ---------------------------------------------------------------------------
  // Eligibility and grant
  // ---------------------------------------------------------------------------
  logic slot0_free, slot1_free;
  logic elig0, elig1;
  logic grant0, grant1;

  // A slot that is being drained this cycle may be refilled in the same cycle.
  assign slot0_free = !rsp0_valid_q || i_rsp0_ready;
  assign slot1_free = !rsp1_valid_q || i_rsp1_ready;
  assign elig0      = i_req0_valid && slot0_free;
  assign elig1      = i_req1_valid && slot1_free;

  // Each grant is built from the eligibility terms, which come only from inputs and
  // registers. It never uses the other port's ready, so no combinational loop can form.
  assign grant0 = !i_reset && elig0 && (!elig1 || !ptr_q);
  assign grant1 = !i_reset && elig1 && (!elig0 ||  ptr_q);

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;

  // ---------------------------------------------------------------------------
  // Shared ALU. Its inputs are held at zero when there is no grant, so idle cycles do not toggle it.
  // ---------------------------------------------------------------------------
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_res;

  always_comb begin
    alu_op = 4'd0;
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    if (grant0) begin
      alu_op = i_req0_alu_op;
      alu_a  = i_req0_op_a;
      alu_b  = i_req0_op_b;
    end else if (grant1) begin
      alu_op = i_req1_alu_op;
      alu_a  = i_req1_op_a;
      alu_b  = i_req1_op_b;
    end
  end

  alu u_alu (
    .alu_op_i (alu_op),
    .op_a_i   (alu_a),
    .op_b_i   (alu_b),
    .result_o (alu_res)
  );

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    ptr_d        = ptr_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp0_tag_d   = rsp0_tag_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    rsp1_tag_d   = rsp1_tag_q;

    if (grant0) ptr_d = 1'b1;
    if (grant1) ptr_d = 1'b0;

    // A load takes priority over a drain, so a drain with a refill keeps valid high.
    if (grant0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = alu_res;
      rsp0_tag_d   = i_req0_tag;
    end else if (i_rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    if (grant1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = alu_res;
      rsp1_tag_d   = i_req1_tag;
    end else if (i_rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= 32'd0;
      rsp0_tag_q   <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= 32'd0;
      rsp1_tag_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp0_tag_q   <= rsp0_tag_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp1_tag_q   <= rsp1_tag_d;
    end
  end

  assign o_rsp0_valid = rsp0_valid_q;
  assign o_rsp0_data  = rsp0_data_q;
  assign o_rsp0_tag   = rsp0_tag_q;
  assign o_rsp1_valid = rsp1_valid_q;
  assign o_rsp1_data  = rsp1_data_q;
  assign o_rsp1_tag   = rsp1_tag_q;

  // ---------------------------------------------------------------------------
  // Statistics. The counters wrap naturally at 2^32.
  // ---------------------------------------------------------------------------
`ifdef ALU_ARBITER_STATS_EN
  logic [31:0] grant_cnt0_q, grant_cnt0_d;
  logic [31:0] grant_cnt1_q, grant_cnt1_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    grant_cnt0_d   = grant_cnt0_q + {31'd0, grant0};
    grant_cnt1_d   = grant_cnt1_q + {31'd0, grant1};
    conflict_cnt_d = conflict_cnt_q + {31'd0, elig0 && elig1};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      grant_cnt0_q   <= 32'd0;
      grant_cnt1_q   <= 32'd0;
      conflict_cnt_q <= 32'd0;
    end else begin
      grant_cnt0_q   <= grant_cnt0_d;
      grant_cnt1_q   <= grant_cnt1_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign o_grant_cnt0   = grant_cnt0_q;
  assign o_grant_cnt1   = grant_cnt1_q;
  assign o_conflict_cnt = conflict_cnt_q;
`else
  assign o_grant_cnt0   = 32'd0;
  assign o_grant_cnt1   = 32'd0;
  assign o_conflict_cnt = 32'd0;
`endif

endmodule
